alu_exec_ctrl: RTL and testbench

Multi-cycle execute sequencer for the 16-bit Harvard datapath. It accepts one 32-bit instruction word at a time and reads the source operands from the single-port register file. It then drives the shared ALU, waits for multi-cycle units (divider), and writes one or two 16-bit results back. It sits between instruction fetch and the ALU/register file, and replaces the combinational always-read/always-write coupling with an explicit handshake and ordered register-file accesses.

---
 rtl/hpu_pkg.sv | 50 +++++
 rtl/alu_wait_timer.sv | 38 +++
 rtl/alu_exec_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpu_pkg.sv
// Shared definitions for the 16-bit Harvard datapath execute stage:
// opcodes, instruction field positions, sequencer states and opcode legality.
package hpu_pkg;

    localparam logic [5:0] OP_MOVI = 6'd0;
    localparam logic [5:0] OP_MOVR = 6'd1;
    localparam logic [5:0] OP_ADD  = 6'd4;
    localparam logic [5:0] OP_SUB  = 6'd5;
    localparam logic [5:0] OP_AND  = 6'd6;
    localparam logic [5:0] OP_MUL  = 6'd7;
    localparam logic [5:0] OP_DIV  = 6'd8;
    localparam logic [5:0] OP_OR   = 6'd9;
    localparam logic [5:0] OP_XOR  = 6'd10;
    localparam logic [5:0] OP_NAND = 6'd11;
    localparam logic [5:0] OP_NOR  = 6'd12;
    localparam logic [5:0] OP_XNOR = 6'd13;
    localparam logic [5:0] OP_LSH  = 6'd14;
    localparam logic [5:0] OP_ARSH = 6'd15;
    localparam logic [5:0] OP_LRSH = 6'd16;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RD1_HI = 25;
    localparam int RD1_LO = 21;
    localparam int RS1_HI = 20;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 11;
    localparam int RD2_HI = 10;
    localparam int RD2_LO = 6;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam int TMR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_EXEC,
        ST_WAIT,
        ST_WB1,
        ST_WB2
    } exec_state_e;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_MOVI) || (op == OP_MOVR) || ((op >= OP_ADD) && (op <= OP_LRSH));
    endfunction

endpackage

// File: rtl/alu_wait_timer.sv
// Loadable down-counter bounding how long the sequencer waits on the divider;
// expired flags terminal count (zero).
module alu_wait_timer
    import hpu_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute sequencer: reads operands from the single-port register
// file, drives the shared ALU, waits on the divider and writes results back.
//
// state   | meaning
// IDLE    | ready for an instruction; illegal opcodes set err here
// RD_A    | rf_addr = rsrc1
// RD_B    | alu_a holds rsrc1; rf_addr = rsrc2
// EXEC    | alu_b holds rsrc2; alu_start pulse
// WAIT    | divider busy, bounded by the wait timer
// WB1     | write result[15:0] to rdst1
// WB2     | write result[31:16] to rdst2 (MUL only)
module alu_exec_ctrl
    import hpu_pkg::*;
#(
    parameter int DIV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rf_addr,
    output logic        rf_we,
    output logic [15:0] rf_wdata,
    input  logic [15:0] rf_rdata,
    output logic [5:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_start,
    input  logic [31:0] alu_result,
    input  logic        alu_done,
    output logic        done,
    output logic        err
);

    // Outputs are registered with the state they belong to, so each state's
    // strobes and addresses are visible during that state.
    exec_state_e state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [4:0]  rs2_q, rs2_d, rd1_q, rd1_d, rd2_q, rd2_d;
    logic [15:0] res_hi_q, res_hi_d;
    logic [4:0]  rf_addr_q, rf_addr_d;
    logic        rf_we_q, rf_we_d;
    logic [15:0] rf_wdata_q, rf_wdata_d;
    logic [5:0]  alu_op_q, alu_op_d;
    logic [15:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic        alu_start_q, alu_start_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        tmr_load, tmr_dec, tmr_expired;

    logic [5:0]  op_in;
    assign op_in = instr[OPC_HI:OPC_LO];

    alu_wait_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (TMR_W'(DIV_TIMEOUT - 1)),
        .dec      (tmr_dec),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rs2_d       = rs2_q;
        rd1_d       = rd1_q;
        rd2_d       = rd2_q;
        res_hi_d    = res_hi_q;
        rf_addr_d   = rf_addr_q;
        rf_we_d     = 1'b0;
        rf_wdata_d  = rf_wdata_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_start_d = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (!is_legal_op(op_in)) begin
                        err_d = 1'b1;
                    end else begin
                        op_d  = op_in;
                        rs2_d = instr[RS2_HI:RS2_LO];
                        rd1_d = instr[RD1_HI:RD1_LO];
                        rd2_d = instr[RD2_HI:RD2_LO];
                        if (op_in == OP_MOVI) begin
                            state_d    = ST_WB1;
                            rf_we_d    = 1'b1;
                            rf_addr_d  = instr[RD1_HI:RD1_LO];
                            rf_wdata_d = instr[IMM_HI:IMM_LO];
                            done_d     = 1'b1;
                        end else begin
                            state_d   = ST_RD_A;
                            rf_addr_d = instr[RS1_HI:RS1_LO];
                        end
                    end
                end
            end
            ST_RD_A: begin
                state_d   = ST_RD_B;
                alu_a_d   = rf_rdata;
                rf_addr_d = rs2_q;
            end
            ST_RD_B: begin
                // MOV reg already has its operand in alu_a; it never touches the ALU.
                if (op_q == OP_MOVR) begin
                    state_d    = ST_WB1;
                    rf_we_d    = 1'b1;
                    rf_addr_d  = rd1_q;
                    rf_wdata_d = alu_a_q;
                    done_d     = 1'b1;
                end else begin
                    state_d     = ST_EXEC;
                    alu_b_d     = rf_rdata;
                    alu_start_d = 1'b1;
                    alu_op_d    = op_q;
                end
            end
            ST_EXEC: begin
                if (op_q == OP_DIV) begin
                    state_d  = ST_WAIT;
                    tmr_load = 1'b1;
                end else begin
                    state_d    = ST_WB1;
                    res_hi_d   = alu_result[31:16];
                    rf_we_d    = 1'b1;
                    rf_addr_d  = rd1_q;
                    rf_wdata_d = alu_result[15:0];
                    done_d     = (op_q != OP_MUL);
                end
            end
            ST_WAIT: begin
                if (alu_done) begin
                    state_d    = ST_WB1;
                    res_hi_d   = alu_result[31:16];
                    rf_we_d    = 1'b1;
                    rf_addr_d  = rd1_q;
                    rf_wdata_d = alu_result[15:0];
                    done_d     = 1'b1;
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_WB1: begin
                if (op_q == OP_MUL) begin
                    state_d    = ST_WB2;
                    rf_we_d    = 1'b1;
                    rf_addr_d  = rd2_q;
                    rf_wdata_d = res_hi_q;
                    done_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB2: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            rs2_q       <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            res_hi_q    <= '0;
            rf_addr_q   <= '0;
            rf_we_q     <= 1'b0;
            rf_wdata_q  <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rs2_q       <= rs2_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            res_hi_q    <= res_hi_d;
            rf_addr_q   <= rf_addr_d;
            rf_we_q     <= rf_we_d;
            rf_wdata_q  <= rf_wdata_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_start_q <= alu_start_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign rf_addr     = rf_addr_q;
    assign rf_we       = rf_we_q;
    assign rf_wdata    = rf_wdata_q;
    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_start   = alu_start_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a register-file array, a small ALU
// model and a divider that answers a programmable number of cycles after start.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [4:0]  rf_addr;
    logic        rf_we;
    logic [15:0] rf_wdata;
    logic [15:0] rf_rdata;
    logic [5:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic        alu_start;
    logic [31:0] alu_result;
    logic        alu_done = 1'b0;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.DIV_TIMEOUT(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_addr     (rf_addr),
        .rf_we       (rf_we),
        .rf_wdata    (rf_wdata),
        .rf_rdata    (rf_rdata),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_start   (alu_start),
        .alu_result  (alu_result),
        .alu_done    (alu_done),
        .done        (done),
        .err         (err)
    );

    // register file: address is registered by the DUT, data follows it
    logic [15:0] mem [0:31];
    assign rf_rdata = mem[rf_addr];
    always @(posedge clk) if (rf_we) mem[rf_addr] <= rf_wdata;

    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            6'd4:  alu_result = {16'h0, alu_a + alu_b};
            6'd7:  alu_result = 32'(alu_a) * 32'(alu_b);
            6'd8:  alu_result = (alu_b == 16'h0) ? 32'hffff_ffff : {alu_a % alu_b, alu_a / alu_b};
            6'd16: alu_result = {16'h0, alu_a >> alu_b[3:0]};
            default: alu_result = 32'h0;
        endcase
    end

    int div_n = 10;
    bit div_en = 1'b1;
    int div_cnt = 0;
    always @(posedge clk) begin
        alu_done <= 1'b0;
        if (alu_start) begin
            div_cnt <= div_n;
        end else if (div_cnt == 1) begin
            alu_done <= div_en;
            div_cnt  <= 0;
        end else if (div_cnt > 1) begin
            div_cnt <= div_cnt - 1;
        end
    end

    int n_tests = 0;
    int n_fail = 0;
    int lat, err_cyc, n_wr, gap;
    logic [4:0] addr_tr [0:127];
    bit         we_tr   [0:127];
    bit         start_tr[0:127];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] d1,
                                        input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [4:0] d2);
        return {op, d1, s1, s2, d2, 6'd0};
    endfunction

    function automatic logic [31:0] enc_imm(input logic [4:0] d1, input logic [15:0] imm);
        return {6'd0, d1, 5'd0, imm};
    endfunction

    // present one instruction, then trace cycles 1..budget after acceptance
    task automatic issue(input logic [31:0] w, input int budget);
        instr = w;
        instr_valid = 1'b1;
        gap = 0;
        while (!instr_ready && gap < 8) begin
            step();
            gap++;
        end
        step();
        instr_valid = 1'b0;
        lat = -1;
        err_cyc = -1;
        n_wr = 0;
        for (int k = 1; k <= budget; k++) begin
            addr_tr[k]  = rf_addr;
            we_tr[k]    = rf_we;
            start_tr[k] = alu_start;
            if (rf_we) n_wr++;
            if (err && err_cyc < 0) err_cyc = k;
            if (done) begin
                lat = k;
                break;
            end
            step();
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_ready"}, 32'(instr_ready), 32'd1);
        chk({pfx, "_strobes"}, {28'd0, rf_we, alu_start, done, err}, 32'd0);
        chk({pfx, "_rf_addr"}, 32'(rf_addr), 32'd0);
        chk({pfx, "_rf_wdata"}, 32'(rf_wdata), 32'd0);
        chk({pfx, "_alu_ab"}, {alu_a, alu_b}, 32'd0);
        chk({pfx, "_alu_op"}, 32'(alu_op), 32'd0);
    endtask

    int bad;

    initial begin
        #1;
        step();
        step();
        chk_reset("reset");
        rst_n = 1'b1;
        step();

        issue(enc_imm(5'd3, 16'h1234), 10);
        chk("movi_latency", 32'(lat), 32'd1);
        chk("movi_writes", 32'(n_wr), 32'd1);
        chk("movi_addr", 32'(addr_tr[1]), 32'd3);
        step();
        chk("movi_r3", 32'(mem[3]), 32'h1234);

        issue(enc_imm(5'd1, 16'd5), 10);
        issue(enc_imm(5'd2, 16'd7), 10);
        chk("b2b_gap", 32'(gap), 32'd1);

        issue(enc(6'd1, 5'd7, 5'd3, 5'd0, 5'd0), 10);
        chk("movr_latency", 32'(lat), 32'd3);
        step();
        chk("movr_r7", 32'(mem[7]), 32'h1234);

        issue(enc(6'd4, 5'd4, 5'd1, 5'd2, 5'd0), 10);
        chk("add_latency", 32'(lat), 32'd4);
        chk("add_addr_seq", {addr_tr[1], addr_tr[2], addr_tr[4]}, {17'd0, 5'd1, 5'd2, 5'd4});
        chk("add_start", {start_tr[1], start_tr[2], start_tr[3], start_tr[4]}, 32'b0010);
        chk("add_we", {we_tr[1], we_tr[2], we_tr[3], we_tr[4]}, 32'b0001);
        chk("add_operands", {alu_a, alu_b}, {16'd5, 16'd7});
        step();
        chk("add_r4", 32'(mem[4]), 32'd12);

        issue(enc(6'd4, 5'd4, 5'd4, 5'd4, 5'd0), 10);
        step();
        chk("add_src_eq_dst", 32'(mem[4]), 32'd24);

        issue(enc_imm(5'd1, 16'h0100), 10);
        issue(enc_imm(5'd2, 16'h0300), 10);
        issue(enc(6'd7, 5'd5, 5'd1, 5'd2, 5'd6), 10);
        chk("mul_latency", 32'(lat), 32'd5);
        chk("mul_writes", 32'(n_wr), 32'd2);
        chk("mul_wb_addr", {addr_tr[4], addr_tr[5]}, {22'd0, 5'd5, 5'd6});
        step();
        chk("mul_r5_r6", {mem[5], mem[6]}, {16'h0000, 16'h0003});

        issue(enc(6'd7, 5'd10, 5'd1, 5'd2, 5'd10), 10);
        step();
        chk("mul_same_dst", 32'(mem[10]), 32'h0003);

        issue(enc_imm(5'd1, 16'd100), 10);
        issue(enc_imm(5'd2, 16'd7), 10);
        div_n = 10;
        issue(enc(6'd8, 5'd11, 5'd1, 5'd2, 5'd0), 40);
        chk("div_latency", 32'(lat), 32'd15);
        chk("div_writes", 32'(n_wr), 32'd1);
        step();
        chk("div_r11", 32'(mem[11]), 32'd14);

        div_en = 1'b0;
        issue(enc(6'd8, 5'd12, 5'd1, 5'd2, 5'd0), 75);
        chk("divto_no_done", 32'(lat), 32'hffff_ffff);
        chk("divto_err_cycle", 32'(err_cyc), 32'd68);
        chk("divto_writes", 32'(n_wr), 32'd0);
        chk("divto_idle", 32'(instr_ready), 32'd1);
        div_en = 1'b1;

        rst_n = 1'b0;
        #1;
        chk_reset("rst2");
        step();
        rst_n = 1'b1;
        step();

        issue(enc(6'd2, 5'd12, 5'd1, 5'd2, 5'd0), 5);
        chk("illegal2_err", 32'(err_cyc), 32'd1);
        chk("illegal2_no_done", 32'(lat), 32'hffff_ffff);
        chk("illegal2_writes", 32'(n_wr), 32'd0);
        chk("illegal2_idle", 32'(instr_ready), 32'd1);

        instr = enc(6'd4, 5'd13, 5'd1, 5'd2, 5'd0);
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        step();
        chk("abort_in_exec", 32'(alu_start), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("abort");
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) rst_n = 1'b1;
            step();
            if (rf_we || done) bad++;
        end
        chk("abort_quiet", 32'(bad), 32'd0);

        issue(enc(6'd4, 5'd13, 5'd1, 5'd2, 5'd0), 10);
        chk("add_after_rst_lat", 32'(lat), 32'd4);
        step();
        chk("add_after_rst_r13", 32'(mem[13]), 32'd107);

        issue(enc(6'd16, 5'd15, 5'd1, 5'd3, 5'd0), 10);
        chk("lrsh_lat", 32'(lat), 32'd4);
        chk("lrsh_err_clear", 32'(err), 32'd0);
        step();
        chk("lrsh_r15", 32'(mem[15]), 32'd6);

        issue(enc(6'd17, 5'd15, 5'd1, 5'd3, 5'd0), 3);
        chk("illegal17_err", 32'(err_cyc), 32'd1);
        chk("illegal17_writes", 32'(n_wr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
